// File: rtl/dice_pkg.sv
// Shared constants and helpers for the multi-die roller: die sizes, segment codes, FSM states.
package dice_pkg;

  localparam int unsigned MAX_DICE = 7;

  // Die sizes as BCD, indexed by button number.
  localparam logic [15:0] DIE_SIZE [MAX_DICE] = '{
    16'h0004, 16'h0006, 16'h0008, 16'h0010, 16'h0012, 16'h0020, 16'h0100
  };

  // Segment codes, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic [1:0] {StIdle, StSpin, StSettle, StShow} state_e;

  function automatic logic [2:0] lowest_set(input logic [MAX_DICE-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_DICE - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    return (d < 4'd10) ? SEG_TABLE[d] : 7'h00;
  endfunction

  function automatic int unsigned bcd_to_int(input logic [15:0] b);
    int unsigned r;
    r = 0;
    for (int i = 3; i >= 0; i--) begin
      r = r * 10 + 32'(b[4*i +: 4]);
    end
    return r;
  endfunction

endpackage

// File: rtl/dice_engine_multi_if.sv
// Button/tick inputs and display/status outputs of the multi-die roller.
interface dice_engine_multi_if #(
    parameter int unsigned N_DICE   = 7,
    parameter int unsigned N_DIGITS = 3
);
    logic                    tick;
    logic [N_DICE-1:0]       btn;
    logic                    seg_inv;
    logic                    dig_inv;
    logic [6:0]              seg;
    logic [N_DIGITS-1:0]     dig_en;
    logic [4*N_DIGITS-1:0]   value_bcd;
    logic [2:0]              die_sel;
    logic                    busy;
    logic                    done;

    modport master (
        output tick, btn, seg_inv, dig_inv,
        input  seg, dig_en, value_bcd, die_sel, busy, done
    );

    modport slave (
        input  tick, btn, seg_inv, dig_inv,
        output seg, dig_en, value_bcd, die_sel, busy, done
    );
endinterface

// File: rtl/bcd_down_counter.sv
// N-digit BCD down counter over 1..max_val; stepping from 1 wraps to max_val.
module bcd_down_counter #(
    parameter int unsigned N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    input  logic                  step,
    input  logic [4*N_DIGITS-1:0] max_val,
    output logic [4*N_DIGITS-1:0] value
);
    localparam int unsigned W = 4 * N_DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] value_q, value_d, dec;
    logic         borrow;

    always_comb begin
        borrow = 1'b1;
        dec    = value_q;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (borrow) begin
                if (value_q[4*k +: 4] == 4'd0) begin
                    dec[4*k +: 4] = 4'd9;
                end else begin
                    dec[4*k +: 4] = value_q[4*k +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (step) begin
            value_d = (value_q == ONE) ? max_val : dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= ONE;
        else        value_q <= value_d;
    end

    assign value = value_q;
endmodule

// File: rtl/dice_engine_multi.sv
// Multi-die roller: spin while held, decelerate on prescaler ticks, show on a muxed display.
module dice_engine_multi
    import dice_pkg::*;
#(
    parameter int unsigned N_DICE       = 7,
    parameter int unsigned N_DIGITS     = 3,
    parameter int unsigned SETTLE_STEPS = 6,
    parameter int unsigned SETTLE_BASE  = 1
) (
    input logic                clk,
    input logic                rst_n,
    dice_engine_multi_if.slave bus
);
    localparam int unsigned W       = 4 * N_DIGITS;
    localparam int unsigned MAX_INT = SETTLE_BASE << (SETTLE_STEPS - 1);
    localparam int unsigned IW      = $clog2(MAX_INT + 1);
    localparam int unsigned CW      = $clog2(SETTLE_STEPS + 1);
    localparam int unsigned SW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    if (N_DICE == 0 || N_DICE > MAX_DICE) begin : g_dice_chk
        $error("N_DICE out of range of the die size table");
    end
    if (SETTLE_STEPS == 0 || SETTLE_BASE == 0) begin : g_settle_chk
        $error("SETTLE_STEPS and SETTLE_BASE must be non-zero");
    end
    for (genvar i = 0; i < N_DICE; i++) begin : g_size_chk
        if (bcd_to_int(DIE_SIZE[i]) >= 10 ** N_DIGITS) begin : g_err
            $error("die size does not fit in N_DIGITS");
        end
    end

    state_e                state_q;
    logic [2:0]            die_sel_q;
    logic [CW-1:0]         step_cnt_q;
    logic [IW-1:0]         interval_q;
    logic [IW-1:0]         tick_cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic [MAX_DICE-1:0]   btn_prev_q;

    logic [MAX_DICE-1:0]   btn_ext;
    logic [MAX_DICE-1:0]   btn_rise;
    logic [2:0]            load_idx;
    logic [W-1:0]          load_val;
    logic [W-1:0]          max_val;
    logic [W-1:0]          value;
    logic                  held;
    logic                  settle_hit;
    logic                  cnt_load;
    logic                  cnt_step;

    always_comb begin
        btn_ext    = MAX_DICE'(bus.btn);
        btn_rise   = btn_ext & ~btn_prev_q;
        load_idx   = lowest_set(btn_ext);
        load_val   = W'(DIE_SIZE[load_idx]);
        max_val    = W'(DIE_SIZE[die_sel_q]);
        held       = btn_ext[die_sel_q];
        settle_hit = bus.tick && ((tick_cnt_q + 1'b1) == interval_q);
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        unique case (state_q)
            StIdle:   cnt_load = |btn_ext;
            StSpin:   cnt_step = held;
            StSettle: cnt_step = !held && settle_hit;
            StShow:   cnt_load = |btn_rise;
            default:  ;
        endcase
    end

    bcd_down_counter #(
        .N_DIGITS (N_DIGITS)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (load_val),
        .step     (cnt_step),
        .max_val  (max_val),
        .value    (value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            die_sel_q  <= '0;
            step_cnt_q <= '0;
            interval_q <= IW'(SETTLE_BASE);
            tick_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            btn_prev_q <= '0;
        end else begin
            done_q     <= 1'b0;
            btn_prev_q <= btn_ext;
            unique case (state_q)
                StIdle: begin
                    if (|btn_ext) begin
                        die_sel_q <= load_idx;
                        state_q   <= StSpin;
                        busy_q    <= 1'b1;
                    end
                end
                StSpin: begin
                    if (!held) begin
                        state_q    <= StSettle;
                        step_cnt_q <= '0;
                        interval_q <= IW'(SETTLE_BASE);
                        tick_cnt_q <= '0;
                    end
                end
                StSettle: begin
                    // A re-press wins over any tick in the same cycle.
                    if (held) begin
                        state_q <= StSpin;
                    end else if (settle_hit) begin
                        tick_cnt_q <= '0;
                        interval_q <= interval_q << 1;
                        step_cnt_q <= step_cnt_q + 1'b1;
                        if ((step_cnt_q + 1'b1) == CW'(SETTLE_STEPS)) begin
                            state_q <= StShow;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else if (bus.tick) begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                StShow: begin
                    if (|btn_rise) begin
                        die_sel_q <= load_idx;
                        state_q   <= StSpin;
                        busy_q    <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [SW-1:0]       scan_q, scan_d;
    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] dig_en_q, dig_en_d;
    logic [3:0]          cur_digit;
    logic                upper_zero;
    logic                blank;

    always_comb begin
        cur_digit  = 4'd0;
        upper_zero = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (SW'(k) == scan_q) cur_digit = value[4*k +: 4];
            if (SW'(k) >= scan_q && value[4*k +: 4] != 4'd0) upper_zero = 1'b0;
        end
        blank    = (state_q == StSpin) || ((scan_q != '0) && upper_zero);
        seg_d    = blank ? 7'h00 : seg_code(cur_digit);
        dig_en_d = blank ? '0 : (N_DIGITS'(1) << scan_q);
        scan_d   = (scan_q == SW'(N_DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q   <= '0;
            seg_q    <= '0;
            dig_en_q <= '0;
        end else begin
            scan_q   <= scan_d;
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
        end
    end

    assign bus.seg       = bus.seg_inv ? seg_q : ~seg_q;
    assign bus.dig_en    = bus.dig_inv ? dig_en_q : ~dig_en_q;
    assign bus.value_bcd = value;
    assign bus.die_sel   = die_sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_dice_engine_multi.sv
// Randomised scoreboard bench for dice_engine_multi against an arithmetic roll model.
module tb_dice_engine_multi;
    localparam int unsigned N_DICE       = 7;
    localparam int unsigned N_DIGITS     = 3;
    localparam int unsigned SETTLE_STEPS = 6;
    localparam int unsigned SETTLE_BASE  = 1;
    localparam int unsigned SETTLE_TICKS = SETTLE_BASE * ((1 << SETTLE_STEPS) - 1);
    localparam int unsigned SIZES [7] = '{4, 6, 8, 10, 12, 20, 100};
    localparam logic [6:0] SEG_CODE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef struct {
        int unsigned value;
        int unsigned die;
        int unsigned ticks;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int unsigned ticks_sent;
    int unsigned model_val;
    int unsigned model_size;
    exp_t exp_q[$];

    dice_engine_multi_if #(.N_DICE(N_DICE), .N_DIGITS(N_DIGITS)) bus ();

    dice_engine_multi #(
        .N_DICE       (N_DICE),
        .N_DIGITS     (N_DIGITS),
        .SETTLE_STEPS (SETTLE_STEPS),
        .SETTLE_BASE  (SETTLE_BASE)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned roll_down(int unsigned v, int unsigned size, int unsigned n);
        for (int i = 0; i < n; i++) v = (v == 1) ? size : v - 1;
        return v;
    endfunction

    function automatic int unsigned settled_steps(int unsigned ticks);
        int unsigned k, need, acc;
        k = 0; need = SETTLE_BASE; acc = 0;
        while (k < SETTLE_STEPS && acc + need <= ticks) begin
            acc += need; need *= 2; k++;
        end
        return k;
    endfunction

    function automatic logic [31:0] to_bcd(int unsigned v);
        return {20'd0, 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [N_DICE-1:0] b, input int unsigned die);
        bus.btn = b;
        bus.tick = 1'b0;
        model_size = SIZES[die];
        model_val = SIZES[die];
        cyc();
        check("load value", to_bcd(0) | 32'(bus.value_bcd), to_bcd(model_val));
        check("load die", 32'(bus.die_sel), die);
        check("busy after load", 32'(bus.busy), 1);
    endtask

    task automatic hold(input int unsigned n);
        for (int i = 0; i < n; i++) begin
            cyc();
            model_val = roll_down(model_val, model_size, 1);
            check("spin dig_en blank", 32'(bus.dig_en), 0);
            check("spin busy", 32'(bus.busy), 1);
        end
        check("spin value", 32'(bus.value_bcd), to_bcd(model_val));
    endtask

    task automatic release_and_settle(input int unsigned die);
        exp_t e;
        bit   got;
        bus.btn = '0;
        bus.tick = 1'b1;  // lands on the release edge and must not count
        model_val = roll_down(model_val, model_size, SETTLE_STEPS);
        e.value = model_val; e.die = die; e.ticks = SETTLE_TICKS;
        exp_q.push_back(e);
        ticks_sent = 0;
        cyc();
        got = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            bus.tick = ($urandom_range(0, 1) == 0);
            if (bus.tick) ticks_sent++;
            cyc();
        end
        bus.tick = 1'b0;
        if (!got) check("settle timeout", 32'(bus.done), 1);
    endtask

    task automatic settle_partial(input int unsigned n);
        bus.btn = '0;
        bus.tick = 1'b1;
        ticks_sent = 0;
        cyc();
        for (int i = 0; i < n; i++) begin
            bus.tick = ($urandom_range(0, 1) == 0);
            if (bus.tick) ticks_sent++;
            cyc();
        end
        bus.tick = 1'b0;
        model_val = roll_down(model_val, model_size, settled_steps(ticks_sent));
        check("partial settle value", 32'(bus.value_bcd), to_bcd(model_val));
        check("partial settle busy", 32'(bus.busy), 1);
    endtask

    task automatic check_display(input int unsigned v);
        int unsigned dig [N_DIGITS];
        int unsigned nsig, vis, p, k;
        p = 1;
        for (int j = 0; j < N_DIGITS; j++) begin
            dig[j] = (v / p) % 10;
            p *= 10;
        end
        nsig = (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
        vis = 0;
        for (int s = 0; s < N_DIGITS; s++) begin
            cyc();
            if (bus.dig_en == '0) begin
                check("blank seg", 32'(bus.seg), 0);
            end else begin
                k = 0;
                for (int j = 0; j < N_DIGITS; j++) if (bus.dig_en[j]) k = j;
                vis++;
                check("dig_en onehot", 32'($onehot(bus.dig_en)), 1);
                check("digit visible", 32'(k < nsig), 1);
                check("digit seg", 32'(bus.seg), 32'(SEG_CODE[dig[k]]));
            end
        end
        check("visible digits", vis, nsig);
    endtask

    // Scoreboard monitor: every done pulse consumes one expected roll.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected done", 32'(bus.done), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done value", 32'(bus.value_bcd), to_bcd(e.value));
                    check("done die", 32'(bus.die_sel), e.die);
                    check("done ticks", ticks_sent, e.ticks);
                    check("busy at done", 32'(bus.busy), 0);
                end
            end
        end
    end

    initial begin
        int unsigned d, h1, h2;
        checks = 0; errors = 0; ticks_sent = 0;
        rst_n = 1'b0;
        bus.btn = '0; bus.tick = 1'b0; bus.seg_inv = 1'b1; bus.dig_inv = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset value", 32'(bus.value_bcd), 32'h001);
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset die", 32'(bus.die_sel), 0);
        check("reset seg", 32'(bus.seg), 0);
        check("reset dig_en", 32'(bus.dig_en), 0);
        repeat (4) cyc();
        check_display(1);

        // D4: load then ten steps, then full settle.
        press(7'b0000001, 0);
        hold(10);
        check("d4 after 10 steps", 32'(bus.value_bcd), 32'h002);
        release_and_settle(0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 250; i++) begin
                bus.tick = ($urandom_range(0, 1) == 0);
                cyc();
            end
            check("show stable", 32'(bus.value_bcd), to_bcd(model_val));
            check("show busy", 32'(bus.busy), 0);
        end
        bus.tick = 1'b0;
        check_display(model_val);

        // D100: the last settle step wraps 1 -> 100.
        press(7'b1000000, 6);
        hold(94);
        release_and_settle(6);
        check("d100 wrap", 32'(bus.value_bcd), 32'h100);
        check_display(model_val);

        // Two buttons: lowest wins, the other is ignored; re-press during settle.
        h1 = $urandom_range(3, 12);
        h2 = $urandom_range(2, 9);
        press(7'b0010010, 1);
        hold(h1);
        bus.btn = 7'b0000010;
        hold(h2);
        check("multi die", 32'(bus.die_sel), 1);
        settle_partial($urandom_range(5, 20));
        bus.btn = 7'b0000010;
        cyc();
        check("repress keeps value", 32'(bus.value_bcd), to_bcd(model_val));
        check("repress busy", 32'(bus.busy), 1);
        hold($urandom_range(1, 10));
        release_and_settle(1);
        check_display(model_val);

        for (int r = 0; r < 5; r++) begin
            d = $urandom_range(0, N_DICE - 1);
            press(N_DICE'(1) << d, d);
            hold($urandom_range(0, 40));
            release_and_settle(d);
            check_display(model_val);
        end

        // Asynchronous reset mid-settle with inverted pins.
        d = $urandom_range(0, N_DICE - 1);
        press(N_DICE'(1) << d, d);
        hold(5);
        bus.btn = '0;
        bus.tick = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            bus.tick = ($urandom_range(0, 1) == 0);
            cyc();
        end
        bus.tick = 1'b0;
        bus.seg_inv = 1'b0;
        bus.dig_inv = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midreset value", 32'(bus.value_bcd), 32'h001);
        check("midreset die", 32'(bus.die_sel), 0);
        check("midreset busy", 32'(bus.busy), 0);
        check("midreset done", 32'(bus.done), 0);
        check("midreset seg pins", 32'(bus.seg), 32'h7F);
        check("midreset dig pins", 32'(bus.dig_en), 32'h7);
        #20 rst_n = 1'b1;
        repeat (3) cyc();
        check("pending rolls", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dice_engine_multi.md
Name: dice_engine_multi

Overview:
- Parametrised successor to the single-counter dice block.
- Takes a vector of already-debounced die-select buttons and spins an N-digit BCD result counter while a button is held.
- On release, decelerates over a fixed number of prescaler ticks, then latches and shows the roll on an N-digit multiplexed seven-segment display with leading-zero blanking and selectable output polarity.
- Sits between the debouncer bank/prescaler and the top-level pin mapping.

Parameters:
- N_DICE, 7, number of die-select buttons; button i selects die size DIE_SIZE[i] from the package table.
- N_DIGITS, 3, BCD digits of result/display. Elaboration check: every DIE_SIZE[i] < 10**N_DIGITS.
- SETTLE_STEPS, 6, counter steps taken after release before the result is final.
- SETTLE_BASE, 1, tick interval of the first settle step. The interval doubles each step.

Ports:
- clk in 1: single clock (32768 Hz in the target design).
- rst_n in 1: asynchronous, active-low reset. All flops clear immediately on rst_n=0; deassertion is synchronised externally.
- tick in 1: one-cycle prescaler pulse (32 Hz).
- btn in N_DICE: debounced buttons, active high.
- seg_inv in 1: 1 drives segments un-inverted (common cathode), 0 inverts them.
- dig_inv in 1: 1 drives digit enables un-inverted, 0 inverts them.
- seg out 7: segments a..g, registered.
- dig_en out N_DIGITS: one-hot digit enable, registered.
- value_bcd out 4*N_DIGITS: current counter value, digit 0 = LSD.
- die_sel out 3: index of the active die.
- busy out 1: high in SPIN or SETTLE.
- done out 1: one-cycle pulse on entry to SHOW.

Behaviour:
- Reset values:
  - state=IDLE, value_bcd=1, die_sel=0, busy=0, done=0.
  - Scan index=0, seg=0 and dig_en=0 before polarity inversion; the inversion mux is the only logic after the flops.
- Counter:
  - BCD modulo counter over 1..DIE_SIZE[die_sel], counting down.
  - From 1 it wraps to DIE_SIZE. Per-digit borrow: 0 becomes 9 with a borrow into the next digit.
  - One step takes 1 cycle.
- FSM:
  - IDLE: if any btn is set, die_sel is loaded with the lowest set index, value is loaded with DIE_SIZE[die_sel], then go to SPIN. Buttons with higher indices are ignored.
  - SPIN: step the counter every clk while btn[die_sel]=1. Other buttons are ignored. When btn[die_sel]=0, go to SETTLE with step_cnt=0, interval=SETTLE_BASE and a cleared tick counter.
  - SETTLE: count ticks. When the tick count reaches the interval, step the counter once, increment step_cnt, double the interval and clear the tick count. When step_cnt reaches SETTLE_STEPS, go to SHOW and pulse done. A press of btn[die_sel] during SETTLE returns to SPIN and keeps the current value.
  - SHOW: hold the value. A new rising press of any button takes the IDLE-load path in the same cycle.
- Display:
  - The scan index advances every clk, wrapping at N_DIGITS.
  - dig_en is one-hot at the scan index.
  - Digit k is blanked (dig_en bit=0, seg=0) when k>0 and all digits k..N_DIGITS-1 are 0. Digit 0 is never blanked.
  - During SPIN all digits are blanked (dig_en=0), so hold-to-roll is not visible.
  - seg and dig_en are registered. The displayed digit lags the scan index by 1 cycle; this is intended.
  - Non-BCD nibble values (unreachable) decode to all segments off.
- Simultaneous events: a tick arriving in the same cycle as btn release is not counted, because counting begins in SETTLE.
- Reset mid-SPIN or mid-SETTLE returns to the reset values immediately.

Decomposition:
- Package dice_pkg:
  - DIE_SIZE table (4,6,8,10,12,20,100) as BCD constants.
  - Seven-segment code table for 0-9.
  - State enum IDLE/SPIN/SETTLE/SHOW.
  - Function for lowest-set-bit index.
- Sub-module bcd_down_counter:
  - Parametrised by N_DIGITS.
  - Ports: load, load_val, step, max_val, value.
  - Handles wrap from 1 to max.
- The top holds the FSM, settle timer and display scan.

Test Plan:
- Reset then idle, N_DIGITS=3: value_bcd=001, busy=0. dig_en scans only digit 0 (digits 1-2 blanked); seg on digit 0 = "1" code 0000110.
- Hold btn[0] (D4) for 10 clk: value steps 4,3,2,1,4,... With load at cycle 0, value after 10 clk = 2. dig_en=0 and busy=1 throughout.
- Release with SETTLE_STEPS=6, SETTLE_BASE=1: exactly 6 further steps, taken at tick counts 1,2,4,8,16,32 (63 ticks total). done pulses once, then value is stable for 1000 clk.
- D100 via btn[6] with value at 1 and one step: wraps to 100. All 3 digits are displayed; digit 1 ("0") is not blanked because digit 2 is non-zero.
- btn[1] and btn[4] pressed together in IDLE: die_sel=1 (D6), values stay in 1..6. Dropping btn[4] alone has no effect; releasing btn[1] enters SETTLE.
- rst_n low for one cycle mid-SETTLE: all outputs return to reset values asynchronously. With seg_inv=0 and dig_inv=0, the pins read seg=1111111 and dig_en all ones.
